// File: rtl/uart_pkt_arbiter.sv
// uart_pkt_arbiter: round-robin two-channel ADC sample packetiser driving a byte-wide UART transmitter.
// Define UART_PKT_CHECKSUM_EN to append an XOR checksum byte to every packet.
module uart_pkt_arbiter #(
  parameter logic [3:0] HDR_NIBBLE = 4'hA,
  parameter int         GUARD_CYC  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] ch0_data,
  input  logic [11:0] ch1_data,
  input  logic        ch0_valid,
  input  logic        ch1_valid,
  output logic        ch0_ready,
  output logic        ch1_ready,
  output logic        TxD_start,
  output logic [7:0]  TxD_data,
  input  logic        TxD_busy,
  output logic        pkt_active
);
  localparam int CW = GUARD_CYC > 1 ? $clog2(GUARD_CYC) : 1;
  typedef enum logic [2:0] {IDLE, LOAD, SEND, GUARD, WAIT_BUSY} state_t;
  state_t state, state_n;
  logic [1:0] arm;
  logic last, ch_id, gnt, grant;
  logic [11:0] data;
  logic [1:0] idx;
  logic [CW-1:0] cnt;
  logic [7:0] b0, b1, b2, nxt_byte;
  logic last_byte;
  assign b0 = {HDR_NIBBLE, 3'b000, ch_id};
  assign b1 = {4'h0, data[11:8]};
  assign b2 = data[7:0];
`ifdef UART_PKT_CHECKSUM_EN
  assign last_byte = idx == 2'd3;
  assign nxt_byte  = idx == 2'd0 ? b1 : idx == 2'd1 ? b2 : b0 ^ b1 ^ b2;
`else
  assign last_byte = idx == 2'd2;
  assign nxt_byte  = idx == 2'd0 ? b1 : b2;
`endif
  // Ties go to the channel not served last; arm holds off grants for two cycles out of reset.
  assign gnt        = (ch0_valid && ch1_valid) ? ~last : ch1_valid;
  assign grant      = state == IDLE && arm[1] && (ch0_valid || ch1_valid);
  assign pkt_active = state != IDLE;
  always_ff @(posedge clk)
    state <= !rst ? IDLE : state_n;
  always_comb begin
    state_n   = state;
    TxD_start = 1'b0;
    ch0_ready = grant && !gnt;
    ch1_ready = grant && gnt;
    case (state)
      IDLE:      state_n = grant ? LOAD : IDLE;
      LOAD:      state_n = SEND;
      SEND: begin
        TxD_start = !TxD_busy;
        state_n   = TxD_busy ? SEND : GUARD;
      end
      GUARD:     state_n = cnt == CW'(GUARD_CYC - 1) ? WAIT_BUSY : GUARD;
      WAIT_BUSY: state_n = TxD_busy ? WAIT_BUSY : last_byte ? IDLE : SEND;
      default:   state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      arm      <= 2'b00;
      last     <= 1'b1;
      ch_id    <= 1'b0;
      data     <= 12'h000;
      idx      <= 2'd0;
      cnt      <= '0;
      TxD_data <= 8'h00;
    end else begin
      arm <= {arm[0], 1'b1};
      if (grant) begin
        ch_id <= gnt;
        last  <= gnt;
        data  <= gnt ? ch1_data : ch0_data;
      end
      if (state == LOAD) begin
        idx      <= 2'd0;
        TxD_data <= b0;
      end
      cnt <= state == GUARD ? cnt + CW'(1) : '0;
      if (state == WAIT_BUSY && !TxD_busy && !last_byte) begin
        idx      <= idx + 2'd1;
        TxD_data <= nxt_byte;
      end
    end
  end
endmodule

// File: doc/uart_pkt_arbiter.md
UART_PKT_ARBITER -- requirements
Module: uart_pkt_arbiter

Interface
REQ-001 SHALL have parameter HDR_NIBBLE, default 4'hA: upper nibble of every packet header byte.
REQ-002 SHALL have parameter GUARD_CYC, default 1: cycles waited after TxD_start before TxD_busy is sampled.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have ports ch0_data / ch1_data  input  12 each  ADC samples from SPI channel 0 / 1.
REQ-006 SHALL have ports ch0_valid / ch1_valid  input  1 each  sample available; held until accepted.
REQ-007 SHALL have ports ch0_ready / ch1_ready  output  1 each  sample accepted this cycle.
REQ-008 SHALL have port TxD_start  output  1  one-cycle byte-send strobe to UART transmitter.
REQ-009 SHALL have port TxD_data  output  8  byte to send; stable from TxD_start until TxD_busy falls.
REQ-010 SHALL have port TxD_busy  input  1  UART transmitter busy.
REQ-011 SHALL have port pkt_active  output  1  high while a packet is in flight.

Function
REQ-012 SHALL implement FSM states IDLE, LOAD, SEND, GUARD, WAIT_BUSY.
REQ-013 IDLE: if any chN_valid, SHALL grant one channel, assert its chN_ready for exactly one cycle, latch its 12-bit data and channel id, go to LOAD.
REQ-014 Arbitration SHALL be round-robin: both valid -> grant channel not granted last; single valid -> grant it; after reset channel 0 wins the first tie.
REQ-015 A ready SHALL never be asserted for a channel whose valid is low; ch0_ready and ch1_ready SHALL never be high together.
REQ-016 Packet bytes: B0 = {HDR_NIBBLE, 3'b000, ch_id}; B1 = {4'h0, data[11:8]}; B2 = data[7:0].
REQ-017 LOAD: SHALL set byte index 0 and drive TxD_data with B0, go to SEND.
REQ-018 SEND: if TxD_busy low, SHALL pulse TxD_start one cycle and go to GUARD; otherwise remain in SEND with TxD_start low.
REQ-019 GUARD: SHALL wait GUARD_CYC cycles, then go to WAIT_BUSY.
REQ-020 WAIT_BUSY: on TxD_busy low, if last byte sent SHALL return to IDLE, else increment index, drive next byte on TxD_data, go to SEND.
REQ-021 Minimum interval between consecutive TxD_start pulses SHALL be GUARD_CYC+2 cycles.
REQ-022 Changes on chN_data or chN_valid during a packet SHALL not affect the packet in flight.
REQ-023 New requests SHALL be granted only in IDLE; earliest grant after a packet is the cycle after returning to IDLE.
REQ-024 pkt_active SHALL be high in every state except IDLE.
REQ-025 TxD_busy high on entry to SEND (external hold-off) SHALL stall indefinitely without data loss.

Reset
REQ-026 On rising clk with rst low, SHALL enter IDLE; TxD_start=0, TxD_data=8'h00, ch0_ready=0, ch1_ready=0, pkt_active=0, byte index 0, round-robin pointer = channel 1 last granted.
REQ-027 Reset asserted mid-packet SHALL abort the packet immediately; the remaining bytes are never sent and the sample is not re-requested.
REQ-028 No ready or TxD_start SHALL be asserted in the first cycle after rst deasserts.

Configuration
REQ-029 Macro UART_PKT_CHECKSUM_EN defined: packet SHALL be 4 bytes, B3 = B0 ^ B1 ^ B2, sent after B2 under the same handshake.
REQ-030 UART_PKT_CHECKSUM_EN undefined: packet SHALL be 3 bytes, no checksum logic present.

Verification
REQ-031 ch0_valid=1, ch0_data=12'h5A3, TxD_busy idle-low, 1-cycle busy response -> ch0_ready one pulse; bytes A0, 05, A3 (plus 06 with checksum).
REQ-032 Both valid continuously, ch0=12'h001, ch1=12'h7FF -> packets alternate ch0, ch1, ch0; headers A0, A1, A0.
REQ-033 TxD_busy held high 50 cycles while in SEND -> no TxD_start during hold; TxD_data unchanged; first byte sent the cycle busy falls.
REQ-034 rst low during GUARD after B1 -> all outputs reset next edge; no further TxD_start until new valid.
REQ-035 ch1_data changed from 12'h123 to 12'hFFF after grant -> packet carries A1, 01, 23.
REQ-036 Only ch1_valid after reset -> ch1 granted first; ch0_ready never asserted.
